// File: rtl/tsg_bus_arbiter.sv
// Grant arbiter for N requesters sharing one tristate bus: drives one-hot gate enables
// with a guaranteed idle turnaround between owners and an optional hold-time limit.
module tsg_bus_arbiter #(
  parameter int N         = 4,
  parameter int PRIO_MODE = 0,
  parameter int MAX_HOLD  = 8,
  parameter int TURN_CYC  = 1,
  localparam int IW       = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic [N-1:0]  bus_oe,
  output logic [IW-1:0] gnt_id,
  output logic          busy,
  output logic          preempt
);

  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam int TW = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam logic [TW-1:0] TURN_LAST = TW'(TURN_CYC - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_TURN} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [IW-1:0] gnt_id_q, gnt_id_d;
  logic          busy_q, busy_d;
  logic          preempt_q, preempt_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [TW-1:0] turn_cnt_q, turn_cnt_d;

  logic          any_req;
  logic [IW-1:0] win_id;
  logic [N-1:0]  win_onehot;
  logic [IW-1:0] rr_next;
  logic          rel_own, rel_max, arb;

  assign any_req = |req;

  // Round-robin scans downward from the far end so the closest set bit to rr_ptr wins last.
  always_comb begin : winner_sel
    int idx;
    idx    = 0;
    win_id = '0;
    if (PRIO_MODE != 0) begin
      for (int i = 0; i < N; i++) begin
        if (req[i]) win_id = IW'(i);
      end
    end else begin
      for (int k = N - 1; k >= 0; k--) begin
        idx = (int'(rr_ptr_q) + k) % N;
        if (req[idx[IW-1:0]]) win_id = idx[IW-1:0];
      end
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_dec
    assign win_onehot[gi] = (win_id == IW'(gi));
  end

  assign rr_next = (win_id == IW'(N - 1)) ? '0 : win_id + 1'b1;

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    gnt_id_d   = gnt_id_q;
    busy_d     = busy_q;
    preempt_d  = 1'b0;
    rr_ptr_d   = rr_ptr_q;
    hold_cnt_d = hold_cnt_q;
    turn_cnt_d = turn_cnt_q;
    arb        = 1'b0;
    rel_own    = !req[gnt_id_q];
    rel_max    = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST);

    case (state_q)
      ST_IDLE: arb = 1'b1;
      ST_GRANT: begin
        hold_cnt_d = hold_cnt_q + 1'b1;
        if (rel_own || rel_max) begin
          state_d    = ST_TURN;
          gnt_d      = '0;
          busy_d     = 1'b0;
          // An owner that lets go on its last allowed cycle is a normal release.
          preempt_d  = rel_max && !rel_own;
          turn_cnt_d = '0;
        end
      end
      ST_TURN: begin
        turn_cnt_d = turn_cnt_q + 1'b1;
        if (turn_cnt_q == TURN_LAST) begin
          arb     = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (arb && any_req) begin
      state_d    = ST_GRANT;
      gnt_d      = win_onehot;
      gnt_id_d   = win_id;
      busy_d     = 1'b1;
      hold_cnt_d = '0;
      rr_ptr_d   = rr_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      gnt_q      <= '0;
      gnt_id_q   <= '0;
      busy_q     <= 1'b0;
      preempt_q  <= 1'b0;
      rr_ptr_q   <= '0;
      hold_cnt_q <= '0;
      turn_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      gnt_id_q   <= gnt_id_d;
      busy_q     <= busy_d;
      preempt_q  <= preempt_d;
      rr_ptr_q   <= rr_ptr_d;
      hold_cnt_q <= hold_cnt_d;
      turn_cnt_q <= turn_cnt_d;
    end
  end

  assign gnt     = gnt_q;
  assign bus_oe  = gnt_q;
  assign gnt_id  = gnt_id_q;
  assign busy    = busy_q;
  assign preempt = preempt_q;

endmodule

// File: tb/tb_tsg_bus_arbiter.sv
// Bench for tsg_bus_arbiter: a round-robin and a fixed-priority instance, directed
// scenarios with queued expected grants, and a randomized contention run.
module tb_tsg_bus_arbiter;
  localparam int N        = 4;
  localparam int WAIT_MAX = (N - 1) * (8 + 1) + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] req_a = '0, req_b = '0;
  logic [3:0] gnt_a, oe_a, gnt_b, oe_b;
  logic [1:0] id_a, id_b;
  logic       busy_a, pre_a, busy_b, pre_b;

  always #5 clk = ~clk;

  tsg_bus_arbiter #(.N(4), .PRIO_MODE(0), .MAX_HOLD(8), .TURN_CYC(1)) dut_rr (
    .clk(clk), .rst_n(rst_n), .req(req_a), .gnt(gnt_a), .bus_oe(oe_a),
    .gnt_id(id_a), .busy(busy_a), .preempt(pre_a)
  );

  tsg_bus_arbiter #(.N(4), .PRIO_MODE(1), .MAX_HOLD(8), .TURN_CYC(1)) dut_fp (
    .clk(clk), .rst_n(rst_n), .req(req_b), .gnt(gnt_b), .bus_oe(oe_b),
    .gnt_id(id_b), .busy(busy_b), .preempt(pre_b)
  );

  typedef struct {
    int id;
    int len;
    int pre;
    int gap;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  logic use_b = 1'b0;
  logic rnd_mode = 1'b0;

  logic [3:0] m_gnt, m_oe, m_req;
  logic [1:0] m_id;
  logic       m_busy, m_pre;
  assign m_gnt  = use_b ? gnt_b  : gnt_a;
  assign m_oe   = use_b ? oe_b   : oe_a;
  assign m_req  = use_b ? req_b  : req_a;
  assign m_id   = use_b ? id_b   : id_a;
  assign m_busy = use_b ? busy_b : busy_a;
  assign m_pre  = use_b ? pre_b  : pre_a;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input int id, input int len, input int pre, input int gap);
    exp_t e;
    e.id = id; e.len = len; e.pre = pre; e.gap = gap;
    return e;
  endfunction

  // Monitor: pops one expected grant per observed grant and checks bus invariants.
  logic [3:0] prev_gnt;
  int         run_len, idle_len, maxw;
  bit         have_prev;
  exp_t       cur;
  int         waitc[4];

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_gnt = '0; run_len = 0; idle_len = 0; have_prev = 0;
      for (int i = 0; i < 4; i++) waitc[i] = 0;
    end else begin
      chk("onehot_oe", int'($countones(m_oe) <= 1), 1);
      chk("oe_eq_gnt", int'(m_oe), int'(m_gnt));
      if (m_gnt != 0 && prev_gnt == 0) begin
        chk("busy_rise", int'(m_busy), 1);
        if (have_prev) chk("turn_gap_min", int'(idle_len >= 1), 1);
        if (!rnd_mode) begin
          chk("grant_expected", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            chk("gnt_id", int'(m_id), cur.id);
            chk("gnt_vec", int'(m_gnt), 1 << cur.id);
            if (cur.gap >= 0 && have_prev) chk("idle_gap", idle_len, cur.gap);
          end else begin
            cur = mk(-1, -1, 0, -1);
          end
        end
        run_len = 1;
      end else if (m_gnt != 0) begin
        chk("no_owner_switch", int'(m_gnt), int'(prev_gnt));
        run_len++;
      end else if (prev_gnt != 0) begin
        chk("busy_fall", int'(m_busy), 0);
        if (rnd_mode) begin
          chk("hold_max", int'(run_len <= 8), 1);
          if (m_pre) chk("preempt_len", run_len, 8);
        end else begin
          if (cur.len >= 0) chk("hold_len", run_len, cur.len);
          chk("preempt", int'(m_pre), cur.pre);
        end
        idle_len = 1;
        have_prev = 1;
      end else begin
        if (!rnd_mode) chk("preempt_idle", int'(m_pre), 0);
        idle_len++;
      end
      maxw = 0;
      for (int i = 0; i < 4; i++) begin
        if (m_req[i] && !m_gnt[i]) waitc[i]++;
        else waitc[i] = 0;
        if (waitc[i] > maxw) maxw = waitc[i];
      end
      chk("wait_bound", int'(maxw <= WAIT_MAX), 1);
      prev_gnt = m_gnt;
    end
  end

  task automatic wait_gnt(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (m_gnt == 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_grant_seen"}, int'(m_gnt != 0), 1);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (m_gnt != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_release_seen"}, int'(m_gnt == 0), 1);
  endtask

  task automatic do_reset();
    req_a = '0;
    req_b = '0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [1:0] w;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_gnt_a", int'(gnt_a), 0);
    chk("rst_oe_a", int'(oe_a), 0);
    chk("rst_id_a", int'(id_a), 0);
    chk("rst_busy_a", int'(busy_a), 0);
    chk("rst_pre_a", int'(pre_a), 0);
    chk("rst_gnt_b", int'(gnt_b), 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset in the middle of a grant, then latency of a fresh request.
    exp_q.push_back(mk(0, -1, 0, -1));
    req_a = 4'b0001;
    wait_gnt("t1a");
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_gnt", int'(gnt_a), 0);
    chk("async_rst_oe", int'(oe_a), 0);
    chk("async_rst_busy", int'(busy_a), 0);
    req_a = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back(mk(2, 2, 0, -1));
    req_a = 4'b0100;
    @(negedge clk);
    chk("lat_before_edge", int'(gnt_a), 0);
    @(negedge clk);
    chk("lat_gnt", int'(gnt_a), 4'b0100);
    chk("lat_gnt_id", int'(id_a), 2);
    @(posedge clk); #1;
    req_a = '0;
    wait_idle("t1b");

    // Round-robin fairness with everyone requesting.
    do_reset();
    exp_q.push_back(mk(0, 2, 0, -1));
    exp_q.push_back(mk(1, 2, 0, 1));
    exp_q.push_back(mk(2, 2, 0, 1));
    exp_q.push_back(mk(3, 2, 0, 1));
    exp_q.push_back(mk(0, 2, 0, 1));
    req_a = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_gnt("t2");
      w = m_id;
      @(posedge clk); #1;
      if (k == 4) req_a = '0;
      else req_a[w] = 1'b0;
      if (k < 4) begin
        @(posedge clk); #1;
        req_a[w] = 1'b1;
      end
    end
    wait_idle("t2");

    // Hold limit: forced release, then a release that coincides with the limit.
    do_reset();
    exp_q.push_back(mk(0, 8, 1, -1));
    exp_q.push_back(mk(0, 8, 0, 1));
    req_a = 4'b0001;
    wait_gnt("t4a");
    wait_idle("t4a");
    wait_gnt("t4b");
    repeat (7) @(posedge clk);
    #1;
    req_a = '0;
    wait_idle("t5");

    // Fixed priority: a higher request does not cut the current owner.
    do_reset();
    use_b = 1'b1;
    exp_q.push_back(mk(1, 3, 0, -1));
    exp_q.push_back(mk(3, 2, 0, 1));
    exp_q.push_back(mk(0, 2, 0, 1));
    req_b = 4'b0011;
    wait_gnt("t3a");
    @(posedge clk); #1;
    req_b = 4'b1011;
    @(posedge clk); #1;
    req_b = 4'b1001;
    wait_idle("t3a");
    wait_gnt("t3b");
    @(posedge clk); #1;
    req_b = 4'b0001;
    wait_idle("t3b");
    wait_gnt("t3c");
    @(posedge clk); #1;
    req_b = '0;
    wait_idle("t3c");

    // Randomized contention on the round-robin instance.
    do_reset();
    use_b = 1'b0;
    rnd_mode = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 7) == 0) req_a[i] = ~req_a[i];
      end
    end
    req_a = '0;
    wait_idle("t6");
    repeat (3) @(negedge clk);
    rnd_mode = 1'b0;

    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
